// File: rtl/ds18b20_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ds18b20_responder                                             |
// | Purpose  : DS18B20 1-Wire sensor-side model: presence, Skip ROM,         |
// |            Convert T and Read Scratchpad. Optional macro DS18B20_CRC_EN  |
// |            enables the Dallas CRC8 in scratchpad byte 8.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ds18b20_responder #(
  parameter int CLK_PER_US   = 12,
  parameter int RST_MIN_US   = 480,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_US      = 120,
  parameter int SAMPLE_US    = 30,
  parameter int HOLD_US      = 30,
  parameter int CONV_CYC     = 1200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_in,
  output logic        conv_start,
  output logic        conv_busy
);
  localparam int c_rst_min_cyc   = RST_MIN_US * CLK_PER_US;
  localparam int c_pres_wait_cyc = PRES_WAIT_US * CLK_PER_US;
  localparam int c_pres_cyc      = PRES_US * CLK_PER_US;
  localparam int c_sample_cyc    = SAMPLE_US * CLK_PER_US;
  localparam int c_hold_cyc      = HOLD_US * CLK_PER_US;
  localparam int c_low_w  = $clog2(c_rst_min_cyc + 1);
  localparam int c_tmr_w  = $clog2(c_pres_wait_cyc + c_pres_cyc + c_sample_cyc + c_hold_cyc + 1);
  localparam int c_conv_w = $clog2(CONV_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRES_WAIT  = 3'd1,
    S_PRES_DRIVE = 3'd2,
    S_ROM_CMD    = 3'd3,
    S_FUNC_CMD   = 3'd4,
    S_IGNORE     = 3'd5,
    S_CONV       = 3'd6,
    S_TX         = 3'd7
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_dq_s1, r_dq_s2, r_dq_prev;
  logic                 w_fall, w_rise, w_rst_det;
  logic [c_low_w-1:0]   r_low_cnt;
  logic [c_tmr_w-1:0]   r_tmr;
  logic                 w_tmr_zero;
  logic                 r_slot_act, r_drive;
  logic [2:0]           r_bit_cnt;
  logic [6:0]           r_shift;
  logic [7:0]           w_byte;
  logic                 w_sample, w_byte_done;
  logic                 w_wr_state, w_rd_state, w_wr_start, w_rd_start;
  logic [3:0]           r_byte_idx;
  logic [15:0]          r_temp;
  logic [7:0]           w_sp_byte, w_b8;
  logic                 w_tx_bit;
  logic                 r_conv_start, r_conv_busy;
  logic [c_conv_w-1:0]  r_conv_cnt;

  // Bus idles high, so the synchroniser resets to 1 to avoid a fake edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dq_s1   <= 1'b1;
      r_dq_s2   <= 1'b1;
      r_dq_prev <= 1'b1;
    end else begin
      r_dq_s1   <= dq_in;
      r_dq_s2   <= r_dq_s1;
      r_dq_prev <= r_dq_s2;
    end
  end

  assign w_fall    = r_dq_prev & ~r_dq_s2;
  assign w_rise    = ~r_dq_prev & r_dq_s2;
  assign w_rst_det = w_rise && (r_low_cnt >= c_low_w'(c_rst_min_cyc));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || r_dq_s2) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != c_low_w'(c_rst_min_cyc)) begin
      r_low_cnt <= r_low_cnt + c_low_w'(1);
    end
  end

  assign w_wr_state  = (r_state == S_ROM_CMD) || (r_state == S_FUNC_CMD);
  assign w_rd_state  = (r_state == S_CONV) || (r_state == S_TX);
  assign w_wr_start  = w_wr_state & w_fall & ~r_slot_act;
  assign w_rd_start  = w_rd_state & w_fall & ~r_drive;
  assign w_tmr_zero  = (r_tmr == '0);
  assign w_sample    = r_slot_act & w_tmr_zero & ~w_rst_det;
  assign w_byte      = {r_dq_s2, r_shift};
  assign w_byte_done = w_sample && (r_bit_cnt == 3'd7);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tmr <= '0;
    end else if (w_rst_det) begin
      r_tmr <= c_tmr_w'(c_pres_wait_cyc - 1);
    end else if ((r_state == S_PRES_WAIT) && w_tmr_zero) begin
      r_tmr <= c_tmr_w'(c_pres_cyc - 1);
    end else if (w_wr_start) begin
      r_tmr <= c_tmr_w'(c_sample_cyc - 1);
    end else if (w_rd_start) begin
      r_tmr <= c_tmr_w'(c_hold_cyc - 1);
    end else if (!w_tmr_zero) begin
      r_tmr <= r_tmr - c_tmr_w'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_rst_det) begin
      r_slot_act <= 1'b0;
      r_drive    <= 1'b0;
    end else begin
      if (w_wr_start)
        r_slot_act <= 1'b1;
      else if (r_slot_act && w_tmr_zero)
        r_slot_act <= 1'b0;
      if (w_rd_start)
        r_drive <= ~w_tx_bit;
      else if (r_drive && w_tmr_zero)
        r_drive <= 1'b0;
    end
  end

  // The bit counter serves both received command bytes and transmitted bits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
    end else if (w_rst_det || !(w_wr_state || (r_state == S_TX))) begin
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_sample) begin
        r_shift   <= w_byte[7:1];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == S_TX) && w_rd_start) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if ((r_bit_cnt == 3'd7) && (r_byte_idx != 4'd9))
          r_byte_idx <= r_byte_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_sp_byte = 8'hFF;
    case (r_byte_idx)
      4'd0:    w_sp_byte = r_temp[7:0];
      4'd1:    w_sp_byte = r_temp[15:8];
      4'd2:    w_sp_byte = 8'h4B;
      4'd3:    w_sp_byte = 8'h46;
      4'd4:    w_sp_byte = 8'h7F;
      4'd5:    w_sp_byte = 8'hFF;
      4'd6:    w_sp_byte = 8'h0C;
      4'd7:    w_sp_byte = 8'h10;
      4'd8:    w_sp_byte = w_b8;
      default: w_sp_byte = 8'hFF;
    endcase
  end

  assign w_tx_bit = (r_state == S_CONV) ? ~r_conv_busy : w_sp_byte[r_bit_cnt];

`ifdef DS18B20_CRC_EN
  logic [7:0] r_crc;
  logic       w_crc_fb;
  assign w_crc_fb = r_crc[0] ^ w_tx_bit;
  // CRC accumulates over bytes 0..7 as they go out and is frozen for byte 8.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || (r_state != S_TX)) begin
      r_crc <= 8'h00;
    end else if (w_rd_start && (r_byte_idx < 4'd8)) begin
      r_crc <= {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
    end
  end
  assign w_b8 = r_crc;
`else
  assign w_b8 = 8'h00;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_temp       <= 16'h0550;
      r_conv_start <= 1'b0;
      r_conv_busy  <= 1'b0;
      r_conv_cnt   <= '0;
    end else begin
      r_conv_start <= 1'b0;
      if (w_byte_done && (r_state == S_FUNC_CMD) && (w_byte == 8'h44)) begin
        r_temp       <= temp_in;
        r_conv_start <= 1'b1;
        r_conv_busy  <= 1'b1;
        r_conv_cnt   <= '0;
      end else if (r_conv_busy) begin
        if (r_conv_cnt == c_conv_w'(CONV_CYC - 1))
          r_conv_busy <= 1'b0;
        else
          r_conv_cnt <= r_conv_cnt + c_conv_w'(1);
      end
    end
  end

  assign conv_start = r_conv_start;
  assign conv_busy  = r_conv_busy;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    dq_oe       = r_drive | (r_state == S_PRES_DRIVE);
    if (w_rst_det) begin
      w_state_nxt = S_PRES_WAIT;
    end else begin
      case (r_state)
        S_PRES_WAIT:  if (w_tmr_zero) w_state_nxt = S_PRES_DRIVE;
        S_PRES_DRIVE: if (w_tmr_zero) w_state_nxt = S_ROM_CMD;
        S_ROM_CMD:
          if (w_byte_done)
            w_state_nxt = (w_byte == 8'hCC) ? S_FUNC_CMD : S_IGNORE;
        S_FUNC_CMD:
          if (w_byte_done) begin
            case (w_byte)
              8'h44:   w_state_nxt = S_CONV;
              8'hBE:   w_state_nxt = S_TX;
              default: w_state_nxt = S_IGNORE;
            endcase
          end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
